// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle RV32M multiply/divide unit with valid/ready handshake and flush.
// Define MDU_DIV_EN to build the radix-2 restoring divider; without it DIV/REM ops return 0 after one cycle.
module mdu_ctrl #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
`ifdef MDU_DIV_EN
    localparam logic [1:0] ST_DIV  = 2'd2;
`endif
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
        neg_if = neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    logic [1:0]      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]      op_r;
    logic [XLEN-1:0] opa_r;
    logic [XLEN-1:0] opb_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [XLEN-1:0] result_r;

    logic [1:0]        mul_op_s;
    logic [XLEN-1:0]   mul_a_s;
    logic [XLEN-1:0]   mul_b_s;
    logic              a_sgn_s;
    logic              b_sgn_s;
    logic [2*XLEN-1:0] a_ext_s;
    logic [2*XLEN-1:0] b_ext_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   mul_res_s;

    // Multiplier: operands come straight from the ports while idle so MUL_LAT==1 can finish at accept.
    always_comb begin
        if (state_r == ST_IDLE) begin
            mul_op_s = op[1:0];
            mul_a_s  = rs1;
            mul_b_s  = rs2;
        end else begin
            mul_op_s = op_r;
            mul_a_s  = opa_r;
            mul_b_s  = opb_r;
        end
        a_sgn_s = (mul_op_s == 2'b01) || (mul_op_s == 2'b10);
        b_sgn_s = (mul_op_s == 2'b01);
        a_ext_s = {{XLEN{a_sgn_s & mul_a_s[XLEN-1]}}, mul_a_s};
        b_ext_s = {{XLEN{b_sgn_s & mul_b_s[XLEN-1]}}, mul_b_s};
        prod_s  = a_ext_s * b_ext_s;
        if (mul_op_s == 2'b00) begin
            mul_res_s = prod_s[XLEN-1:0];
        end else begin
            mul_res_s = prod_s[2*XLEN-1:XLEN];
        end
    end

`ifdef MDU_DIV_EN
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] dvs_r;
    logic            q_neg_r;
    logic            r_neg_r;

    logic            div_sgn_s;
    logic            a_neg_s;
    logic            b_neg_s;
    logic            div_zero_s;
    logic            div_ovf_s;
    logic [XLEN-1:0] spec_res_s;
    logic [XLEN:0]   rem_sh_s;
    logic [XLEN:0]   diff_s;
    logic [XLEN-1:0] rem_nx_s;
    logic [XLEN-1:0] quo_nx_s;
    logic [XLEN-1:0] div_res_s;

    // Divider: operand preparation at accept, one restoring step per cycle, sign fixup on the last step.
    always_comb begin
        div_sgn_s  = ~op[0];
        a_neg_s    = div_sgn_s & rs1[XLEN-1];
        b_neg_s    = div_sgn_s & rs2[XLEN-1];
        div_zero_s = (rs2 == {XLEN{1'b0}});
        div_ovf_s  = div_sgn_s & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == {XLEN{1'b1}});
        if (div_zero_s) begin
            spec_res_s = op[1] ? rs1 : {XLEN{1'b1}};
        end else if (div_ovf_s) begin
            spec_res_s = op[1] ? {XLEN{1'b0}} : rs1;
        end else begin
            spec_res_s = {XLEN{1'b0}};
        end
        rem_sh_s = {rem_r, quo_r[XLEN-1]};
        diff_s   = rem_sh_s - {1'b0, dvs_r};
        if (diff_s[XLEN]) begin
            rem_nx_s = rem_sh_s[XLEN-1:0];
        end else begin
            rem_nx_s = diff_s[XLEN-1:0];
        end
        quo_nx_s = {quo_r[XLEN-2:0], ~diff_s[XLEN]};
        if (op_r[1]) begin
            div_res_s = neg_if(r_neg_r, rem_nx_s);
        end else begin
            div_res_s = neg_if(q_neg_r, quo_nx_s);
        end
    end
`endif

    // Sequencing FSM with registered handshake outputs and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            op_r        <= 2'b00;
            opa_r       <= {XLEN{1'b0}};
            opb_r       <= {XLEN{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= {XLEN{1'b0}};
`ifdef MDU_DIV_EN
            rem_r       <= {XLEN{1'b0}};
            quo_r       <= {XLEN{1'b0}};
            dvs_r       <= {XLEN{1'b0}};
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else if (flush) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r       <= op[1:0];
                        opa_r      <= rs1;
                        opb_r      <= rs2;
                        in_ready_r <= 1'b0;
                        if (!op[2]) begin
                            if (MUL_LAT <= 1) begin
                                result_r    <= mul_res_s;
                                out_valid_r <= 1'b1;
                                state_r     <= ST_DONE;
                            end else begin
                                cnt_r   <= MUL_CNT_INIT;
                                state_r <= ST_MUL;
                            end
                        end else begin
`ifdef MDU_DIV_EN
                            if (div_zero_s || div_ovf_s) begin
                                result_r    <= spec_res_s;
                                out_valid_r <= 1'b1;
                                state_r     <= ST_DONE;
                            end else begin
                                rem_r   <= {XLEN{1'b0}};
                                quo_r   <= neg_if(a_neg_s, rs1);
                                dvs_r   <= neg_if(b_neg_s, rs2);
                                q_neg_r <= a_neg_s ^ b_neg_s;
                                r_neg_r <= a_neg_s;
                                cnt_r   <= CNT_W'(XLEN - 1);
                                state_r <= ST_DIV;
                            end
`else
                            result_r    <= {XLEN{1'b0}};
                            out_valid_r <= 1'b1;
                            state_r     <= ST_DONE;
`endif
                        end
                    end
                end
                ST_MUL: begin
                    if (cnt_r == CNT_ZERO) begin
                        result_r    <= mul_res_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
`ifdef MDU_DIV_EN
                ST_DIV: begin
                    rem_r <= rem_nx_s;
                    quo_r <= quo_nx_s;
                    if (cnt_r == CNT_ZERO) begin
                        result_r    <= div_res_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: scoreboard of expected result/latency, plus flush and reset scenarios.
module tb_mdu_ctrl;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   errors;

    mdu_ctrl #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        int          ia;
        int          ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        e.lat = MUL_LAT;
        case (o)
            3'b000: begin p = {32'h0, a} * {32'h0, b}; e.res = p[31:0];  end
            3'b001: begin p = sa * sb;                 e.res = p[63:32]; end
            3'b010: begin p = sa * ub;                 e.res = p[63:32]; end
            3'b011: begin p = {32'h0, a} * {32'h0, b}; e.res = p[63:32]; end
            default: begin
                ia = $signed(a);
                ib = $signed(b);
                e.lat = 1;
                if (!DIV_EN) begin
                    e.res = 32'h0;
                end else if (b == 32'h0) begin
                    e.res = o[1] ? a : 32'hFFFF_FFFF;
                end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.res = o[1] ? 32'h0 : a;
                end else begin
                    e.lat = XLEN + 1;
                    if (!o[0]) e.res = o[1] ? 32'(ia % ib) : 32'(ia / ib);
                    else       e.res = o[1] ? (a % b) : (a / b);
                end
            end
        endcase
        return e;
    endfunction

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val({tag, "_ready"}, in_ready, 1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        int   lat;
        exp_t e;
        wait_ready(tag);
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        rs1      = a;
        rs2      = b;
        sb_q.push_back(model(o, a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        rs1      = $urandom;
        rs2      = $urandom;
        check_val({tag, "_busy"}, in_ready, 0);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb_q.pop_front();
        check_val({tag, "_lat"}, lat, e.lat);
        check_val({tag, "_res"}, result, e.res);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val({tag, "_hold_valid"}, out_valid, 1);
            check_val({tag, "_hold_res"}, result, e.res);
            check_val({tag, "_hold_ready"}, in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val({tag, "_taken_valid"}, out_valid, 0);
        check_val({tag, "_taken_ready"}, in_ready, 1);
    endtask

    initial begin
        int pre;
        int post;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 3'b000;
        rs1       = 32'h0;
        rs2       = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_ready", in_ready, 1);
        check_val("reset_valid", out_valid, 0);
        check_val("reset_result", result, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul_7x6",     3'b000, 32'd7, 32'd6, 0);
        run_op("mulh_m1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhu_max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhsu_m1",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("div_m20_3",   3'b100, 32'hFFFF_FFEC, 32'd3, 0);
        run_op("rem_m20_3",   3'b110, 32'hFFFF_FFEC, 32'd3, 0);
        run_op("divu_100_7",  3'b101, 32'd100, 32'd7, 5);
        run_op("remu_100_7",  3'b111, 32'd100, 32'd7, 0);
        run_op("divu_by0",    3'b101, 32'h1234_5678, 32'h0, 0);
        run_op("remu_5_by0",  3'b111, 32'd5, 32'h0, 0);
        run_op("div_by0",     3'b100, 32'hFFFF_FFEC, 32'h0, 0);
        run_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("div_min_3",   3'b100, 32'h8000_0000, 32'd3, 0);
        run_op("mul_hold",    3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 5);
        for (int i = 0; i < 8; i++) begin
            run_op("rand", 3'($urandom_range(0, 7)), $urandom, $urandom, i % 2);
        end

        // flush mid-divide: nothing may come out, and the unit must be reusable
        wait_ready("flush_div");
        @(negedge clk);
        in_valid = 1'b1;
        op       = 3'b100;
        rs1      = 32'hFFFF_FFEC;
        rs2      = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        pre = out_valid;
        repeat (8) begin
            @(posedge clk); #1;
            pre += out_valid;
        end
        check_val("flush_pre_valid", pre, DIV_EN ? 0 : 9);
        @(negedge clk);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        check_val("flush_valid", out_valid, 0);
        check_val("flush_ready", in_ready, 1);
        post = 0;
        repeat (40) begin
            @(posedge clk); #1;
            post += out_valid;
        end
        check_val("flush_post_valid", post, 0);
        run_op("mul_3x3", 3'b000, 32'd3, 32'd3, 0);

        // flush beats in_valid in IDLE
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        op       = 3'b000;
        rs1      = 32'd5;
        rs2      = 32'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check_val("flush_noacc_ready", in_ready, 1);
        post = 0;
        repeat (4) begin
            @(posedge clk); #1;
            post += out_valid;
        end
        check_val("flush_noacc_valid", post, 0);

        // synchronous reset in the middle of a divide
        @(negedge clk);
        in_valid = 1'b1;
        op       = 3'b101;
        rs1      = 32'd100;
        rs2      = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("rst_mid_ready", in_ready, 1);
        check_val("rst_mid_valid", out_valid, 0);
        check_val("rst_mid_result", result, 0);
        post = 0;
        repeat (40) begin
            @(posedge clk); #1;
            post += out_valid;
        end
        check_val("rst_mid_post_valid", post, 0);
        run_op("mul_after_rst", 3'b000, 32'd11, 32'd13, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
